// File: rtl/uart_pkg.sv
// Shared types and line-level constants for the UART transmitter.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS   = 8;
    localparam int unsigned UART_BITCNT_W    = $clog2(UART_DATA_BITS);
    localparam logic        UART_IDLE_LEVEL  = 1'b1;
    localparam logic        UART_START_LEVEL = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter: o_done_c marks the last cycle of a short
// (CLKS_PER_BIT) or long (CLKS_PER_BIT*MAX_MULT) period, then wraps to zero.
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 3,
    parameter int unsigned MAX_MULT     = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    input  logic i_long,
    output logic o_done_c
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT * MAX_MULT) + 1;

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_limit;

    assign w_limit  = i_long ? CW'(CLKS_PER_BIT * MAX_MULT - 1) : CW'(CLKS_PER_BIT - 1);
    assign o_done_c = (r_cnt == w_limit);

    always_ff @(posedge clk) begin
        if (rst || i_restart || o_done_c) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter with one-byte holding register, LSB-first 8N1/8N2 frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 3,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [UART_DATA_BITS-1:0] i_data,
    input  logic                      i_req,
    output logic                      o_cts,
    output logic                      o_idle,
    output logic                      o_serial
);

    tx_state_t                 r_state;
    logic [UART_DATA_BITS-1:0] r_buf;
    logic                      r_buf_valid;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_BITCNT_W-1:0]  r_bit_cnt;
    logic                      r_serial;
    logic                      r_idle;
`ifdef UART_TX_PARITY_EN
    logic                      r_parity;
`endif

    logic w_done;
    logic w_accept;
    logic w_stop_end;
    logic w_frame_free;
    logic w_load;
    logic w_to_idle;
    logic w_buf_valid_nxt;

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .MAX_MULT     (STOP_BITS)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_restart (w_load),
        .i_long    (r_state == STOP),
        .o_done_c  (w_done)
    );

    // Shifter may be loaded from IDLE or on the last stop cycle (back-to-back).
    assign w_accept        = i_req && !r_buf_valid;
    assign w_stop_end      = (r_state == STOP) && w_done;
    assign w_frame_free    = (r_state == IDLE) || w_stop_end;
    assign w_load          = r_buf_valid && w_frame_free;
    assign w_to_idle       = !r_buf_valid && w_frame_free;
    assign w_buf_valid_nxt = w_accept || (r_buf_valid && !w_load);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_buf       <= '0;
            r_buf_valid <= 1'b0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_serial    <= UART_IDLE_LEVEL;
            r_idle      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            r_buf_valid <= w_buf_valid_nxt;
            r_idle      <= w_to_idle && !w_buf_valid_nxt;
            if (w_accept) begin
                r_buf <= i_data;
            end

            if (w_load) begin
                r_shift  <= r_buf;
                r_state  <= START;
                r_serial <= UART_START_LEVEL;
`ifdef UART_TX_PARITY_EN
                r_parity <= ^r_buf;
`endif
            end else begin
                case (r_state)
                    START: begin
                        if (w_done) begin
                            r_state   <= DATA;
                            r_bit_cnt <= '0;
                            r_serial  <= r_shift[0];
                        end
                    end
                    DATA: begin
                        if (w_done) begin
                            r_bit_cnt <= r_bit_cnt + UART_BITCNT_W'(1);
                            if (r_bit_cnt == UART_BITCNT_W'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                                r_state  <= PARITY;
                                r_serial <= r_parity;
`else
                                r_state  <= STOP;
                                r_serial <= UART_IDLE_LEVEL;
`endif
                            end else begin
                                r_shift  <= r_shift >> 1;
                                r_serial <= r_shift[1];
                            end
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        if (w_done) begin
                            r_state  <= STOP;
                            r_serial <= UART_IDLE_LEVEL;
                        end
                    end
`endif
                    STOP: begin
                        if (w_done) begin
                            r_state  <= IDLE;
                            r_serial <= UART_IDLE_LEVEL;
                        end
                    end
                    default: begin
                        r_state  <= IDLE;
                        r_serial <= UART_IDLE_LEVEL;
                    end
                endcase
            end
        end
    end

    assign o_cts    = !r_buf_valid;
    assign o_idle   = r_idle;
    assign o_serial = r_serial;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a line decoder captures every frame cycle by
// cycle and compares it with the frame expected for each byte queued by the stimulus.
module tb_uart_tx;

    localparam int unsigned CPB = 3;
    localparam int unsigned SB  = 1;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned PAR = 1;
`else
    localparam int unsigned PAR = 0;
`endif
    localparam int unsigned FRAME = CPB * (10 + (SB - 1) + PAR);

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] i_data;
    logic       i_req;
    logic       o_cts;
    logic       o_idle;
    logic       o_serial;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0]  exp_q[$];
    logic        active = 1'b0;
    int          ncap   = 0;
    logic [63:0] cap;

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .STOP_BITS    (SB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_data   (i_data),
        .i_req    (i_req),
        .o_cts    (o_cts),
        .o_idle   (o_idle),
        .o_serial (o_serial)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Per-cycle line level of a complete frame for byte b.
    function automatic logic [63:0] frame_pat(input logic [7:0] b);
        logic [15:0] bits;
        logic [63:0] pat;
        int nb;
        bits = '0;
        pat  = '0;
        for (int i = 0; i < 8; i++) bits[1 + i] = b[i];
        nb = 9;
        if (PAR != 0) begin
            bits[nb] = ^b;
            nb++;
        end
        for (int s = 0; s < int'(SB); s++) begin
            bits[nb] = 1'b1;
            nb++;
        end
        for (int c = 0; c < int'(FRAME); c++) pat[c] = bits[c / int'(CPB)];
        return pat;
    endfunction

    // Line decoder: a low level while idle starts a frame of FRAME cycles.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            active = 1'b0;
            ncap   = 0;
            exp_q.delete();
        end else if (!active) begin
            if (o_serial === 1'b0) begin
                active = 1'b1;
                cap    = '0;
                ncap   = 1;
            end
        end else begin
            cap[ncap] = o_serial;
            ncap++;
            if (ncap == int'(FRAME)) begin
                active = 1'b0;
                chk("frame_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    logic [7:0] b;
                    b = exp_q.pop_front();
                    chk($sformatf("frame_%02h", b), cap, frame_pat(b));
                end
            end
        end
    end

    // Present a byte from a negedge; returns the cycle count of the accepting edge.
    task automatic send(input logic [7:0] b, output int acc);
        exp_q.push_back(b);
        i_data = b;
        i_req  = 1'b1;
        acc    = -1;
        for (int w = 0; w < 200; w++) begin
            if (o_cts === 1'b1) begin
                @(posedge clk);
                @(negedge clk);
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        i_req = 1'b0;
        chk("accept_seen", 64'(acc >= 0), 64'd1);
    endtask

    task automatic wait_idle(output int at);
        at = -100000;
        for (int w = 0; w < 300; w++) begin
            @(negedge clk);
            if (o_idle === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        int a1, a2, a3, t;
        rst    = 1'b1;
        i_req  = 1'b0;
        i_data = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("reset_quiet", {o_serial, o_cts, o_idle}, 64'b111);
        end

        // single byte: cts/idle timing and start-bit latency
        send(8'h55, a1);
        chk("cts_low_after_accept", o_cts, 64'd0);
        chk("idle_low_after_accept", o_idle, 64'd0);
        @(negedge clk);
        chk("cts_back", o_cts, 64'd1);
        chk("start_bit_latency", o_serial, 64'd0);
        wait_idle(t);
        chk("idle_delay_55", 64'(t - a1), 64'(FRAME + 1));

        // back-to-back frames with continuous request
        send(8'h41, a1);
        send(8'h42, a2);
        chk("b2b_accept_gap", 64'(a2 - a1), 64'd2);
        wait_idle(t);
        chk("b2b_span", 64'(t - a1), 64'(2 * FRAME + 1));

        // full holding register blocks a third byte until the shifter reloads
        send(8'h11, a1);
        send(8'h22, a2);
        i_data = 8'hAA;
        i_req  = 1'b1;
        chk("full_cts_low", o_cts, 64'd0);
        send(8'hAA, a3);
        chk("full_accept_edge", 64'(a3 - a1), 64'(FRAME + 2));
        wait_idle(t);
        chk("full_span", 64'(t - a1), 64'(3 * FRAME + 1));

        // reset mid-frame with a byte buffered
        repeat (2) @(negedge clk);
        send(8'h00, a1);
        send(8'h33, a2);
        while (cyc < a1 + 12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_midframe_outputs", {o_serial, o_cts, o_idle}, 64'b111);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_discard_quiet", {o_serial, o_idle}, 64'b11);
        end
        send(8'h0F, a1);
        wait_idle(t);
        chk("post_rst_frame_len", 64'(t - a1), 64'(FRAME + 1));

        // odd-weight byte: parity bit 1 when enabled, frame length per build
        send(8'h07, a1);
        wait_idle(t);
        chk("frame_len_07", 64'(t - a1), 64'(FRAME + 1));

        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("decoder_idle", 64'(active), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
